packer_fsm: RTL and testbench

- Packs a stream of 32-byte words (val/sop/eop/vbc, vbc 1..32) into 160-byte wide beats with a total byte count.
- It is the transmit-side counterpart of the 160B-to-32B unpack path, and feeds any consumer of the wide 160-byte bus.
- Packets longer than 160 bytes leave as several wide beats. Only the first beat carries sop; only the last carries eop.
- A configurable inter-beat gap throttles the narrow side.

---
 rtl/packer_pkg.sv | 20 ++
 rtl/packer_if.sv | 30 +++
 rtl/packer_fsm.sv | 152 +++++++++++++++
 tb/tb_packer_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/packer_pkg.sv
// Shared types and constants for the 32B-to-160B packer.
package packer_pkg;

  localparam int unsigned WORD_BYTES = 32;
  localparam int unsigned MAX_WORDS  = 5;
  localparam int unsigned WORD_W     = 256;
  localparam int unsigned BEAT_W     = 1280;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StGap
  } state_e;

  // A word may carry 1..WORD_BYTES valid bytes.
  function automatic logic vbc_legal(input logic [7:0] vbc);
    return (vbc != 8'd0) && (vbc <= 8'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/packer_if.sv
// Narrow input stream, wide output beat and configuration of the packer.
interface packer_if;
  import packer_pkg::*;

  logic [3:0]        cfg_gap;
  logic              val;
  logic              sop;
  logic              eop;
  logic [7:0]        vbc;
  logic [WORD_W-1:0] data;
  logic              ready;
  logic              o_val;
  logic              o_sop;
  logic              o_eop;
  logic [7:0]        o_vbc;
  logic [BEAT_W-1:0] o_data;
  logic              idle;
  logic              err;

  modport slave (
    input  cfg_gap, val, sop, eop, vbc, data,
    output ready, o_val, o_sop, o_eop, o_vbc, o_data, idle, err
  );

  modport master (
    output cfg_gap, val, sop, eop, vbc, data,
    input  ready, o_val, o_sop, o_eop, o_vbc, o_data, idle, err
  );

endinterface

// File: rtl/packer_fsm.sv
// Packs 32-byte words into 160-byte beats; the beat leaves on the edge that accepts its last word.
module packer_fsm
  import packer_pkg::*;
(
  input logic      clk,
  input logic      reset_L,
  packer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] acc_q, acc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              in_pkt_q, in_pkt_d;
  logic              first_q, first_d;
  logic [3:0]        gap_q, gap_d;
  logic              o_val_q, o_val_d;
  logic              o_sop_q, o_sop_d;
  logic              o_eop_q, o_eop_d;
  logic [7:0]        o_vbc_q, o_vbc_d;
  logic [BEAT_W-1:0] o_data_q, o_data_d;
  logic              err_q, err_d;

  logic [BEAT_W-1:0] acc_nxt;
  logic [7:0]        sum_nxt;
  logic [2:0]        slot, cnt_nxt;
  logic              first_now, short_word, close_beat, keep_pkt;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    in_pkt_d   = in_pkt_q;
    first_d    = first_q;
    gap_d      = gap_q;
    o_val_d    = 1'b0;
    o_sop_d    = 1'b0;
    o_eop_d    = 1'b0;
    o_vbc_d    = 8'd0;
    o_data_d   = '0;
    err_d      = 1'b0;
    acc_nxt    = acc_q;
    sum_nxt    = sum_q;
    slot       = cnt_q;
    cnt_nxt    = cnt_q;
    first_now  = first_q;
    short_word = 1'b0;
    close_beat = 1'b0;
    keep_pkt   = 1'b0;

    if (state_q == StGap) begin
      if (gap_q <= 4'd1) begin
        state_d = in_pkt_q ? StAccum : StIdle;
      end else begin
        gap_d = gap_q - 4'd1;
      end
    end else if (bus.val) begin
      if (!vbc_legal(bus.vbc)) begin
        err_d = 1'b1;
      end else if (!bus.sop && !in_pkt_q) begin
        err_d = 1'b1;
      end else begin
        // A sop mid-packet throws the partial beat away and restarts.
        if (bus.sop) begin
          err_d     = in_pkt_q;
          acc_nxt   = '0;
          sum_nxt   = 8'd0;
          slot      = 3'd0;
          first_now = 1'b1;
        end
        for (int k = 0; k < MAX_WORDS; k++) begin
          if (slot == 3'(k)) acc_nxt[(MAX_WORDS-1-k)*WORD_W +: WORD_W] = bus.data;
        end
        sum_nxt    = sum_nxt + bus.vbc;
        cnt_nxt    = slot + 3'd1;
        short_word = (bus.vbc < 8'(WORD_BYTES)) && !bus.eop;
        close_beat = bus.eop || short_word || (cnt_nxt == 3'(MAX_WORDS));
        if (short_word) err_d = 1'b1;

        if (close_beat) begin
          keep_pkt = !(bus.eop || short_word);
          o_val_d  = 1'b1;
          o_sop_d  = first_now;
          o_eop_d  = !keep_pkt;
          o_vbc_d  = sum_nxt;
          o_data_d = acc_nxt;
          acc_d    = '0;
          cnt_d    = 3'd0;
          sum_d    = 8'd0;
          in_pkt_d = keep_pkt;
          first_d  = 1'b0;
          if (bus.cfg_gap != 4'd0) begin
            state_d = StGap;
            gap_d   = bus.cfg_gap;
          end else begin
            state_d = keep_pkt ? StAccum : StIdle;
          end
        end else begin
          acc_d    = acc_nxt;
          cnt_d    = cnt_nxt;
          sum_d    = sum_nxt;
          in_pkt_d = 1'b1;
          first_d  = first_now;
          state_d  = StAccum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= 3'd0;
      sum_q    <= 8'd0;
      in_pkt_q <= 1'b0;
      first_q  <= 1'b0;
      gap_q    <= 4'd0;
      o_val_q  <= 1'b0;
      o_sop_q  <= 1'b0;
      o_eop_q  <= 1'b0;
      o_vbc_q  <= 8'd0;
      o_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      in_pkt_q <= in_pkt_d;
      first_q  <= first_d;
      gap_q    <= gap_d;
      o_val_q  <= o_val_d;
      o_sop_q  <= o_sop_d;
      o_eop_q  <= o_eop_d;
      o_vbc_q  <= o_vbc_d;
      o_data_q <= o_data_d;
      err_q    <= err_d;
    end
  end

  assign bus.ready  = (state_q != StGap);
  assign bus.idle   = (state_q == StIdle);
  assign bus.o_val  = o_val_q;
  assign bus.o_sop  = o_sop_q;
  assign bus.o_eop  = o_eop_q;
  assign bus.o_vbc  = o_vbc_q;
  assign bus.o_data = o_data_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_packer_fsm.sv
// Directed bench for packer_fsm with a scoreboard of expected wide beats.
module tb_packer_fsm;

  typedef struct {
    int           cyc;
    logic         sop;
    logic         eop;
    logic [7:0]   vbc;
    logic [1279:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   err_seen = 0;
  int   exp_err = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];

  packer_if bus ();

  packer_fsm dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_val) obs_q.push_back('{cyc, bus.o_sop, bus.o_eop, bus.o_vbc, bus.o_data});
    if (bus.err) err_seen++;
  end

  task automatic chk(input string tag, input logic [1279:0] obs, input logic [1279:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [1279:0] put(input logic [1279:0] b, input int k,
                                        input logic [255:0] w);
    b[(4-k)*256 +: 256] = w;
    return b;
  endfunction

  task automatic send(input logic s, input logic e, input logic [7:0] v, input logic [255:0] d,
                      output int acc_cyc, output int waited);
    @(negedge clk);
    bus.val = 1'b1; bus.sop = s; bus.eop = e; bus.vbc = v; bus.data = d;
    waited = 0;
    while (!bus.ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready) chk("ready_timeout", bus.ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.val = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
  endtask

  task automatic push_exp(input int c, input logic s, input logic e, input logic [7:0] v,
                          input logic [1279:0] d);
    exp_q.push_back('{c, s, e, v, d});
  endtask

  task automatic drain();
    beat_t o, x;
    repeat (3) @(negedge clk);
    chk("beat_count", obs_q.size(), exp_q.size());
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      chk("beat_cycle", o.cyc, x.cyc);
      chk("o_sop", o.sop, x.sop);
      chk("o_eop", o.eop, x.eop);
      chk("o_vbc", o.vbc, x.vbc);
      chk("o_data", o.data, x.data);
    end
    obs_q.delete();
    exp_q.delete();
    chk("err_count", err_seen, exp_err);
  endtask

  initial begin
    logic [255:0]  w[8];
    logic [1279:0] b;
    int c, wt;

    bus.cfg_gap = 4'd0; bus.val = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
    bus.vbc = 8'd0; bus.data = '0;
    #3;
    chk("rst_ready", bus.ready, 1);
    chk("rst_idle", bus.idle, 1);
    chk("rst_o_val", bus.o_val, 0);
    chk("rst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    reset_L = 1'b1;

    // 160B packet, back-to-back
    b = '0;
    for (int k = 0; k < 5; k++) begin
      w[k] = rnd_word();
      b = put(b, k, w[k]);
      send(k == 0, k == 4, 8'd32, w[k], c, wt);
    end
    push_exp(c, 1, 1, 8'd160, b);
    drain();
    chk("idle_after_160", bus.idle, 1);

    // 40B packet: lower slices stay zero, partial word passes through unmasked
    w[0] = rnd_word(); w[1] = rnd_word();
    send(1, 0, 8'd32, w[0], c, wt);
    send(0, 1, 8'd8, w[1], c, wt);
    b = put(put('0, 0, w[0]), 1, w[1]);
    push_exp(c, 1, 1, 8'd40, b);
    drain();

    // 200B packet split in two beats with a 3-cycle gap
    bus.cfg_gap = 4'd3;
    for (int k = 0; k < 7; k++) w[k] = rnd_word();
    b = '0;
    for (int k = 0; k < 5; k++) begin
      b = put(b, k, w[k]);
      send(k == 0, 0, 8'd32, w[k], c, wt);
    end
    push_exp(c, 1, 0, 8'd160, b);
    send(0, 0, 8'd32, w[5], c, wt);
    chk("gap_ready_low_cycles", wt, 3);
    send(0, 1, 8'd8, w[6], c, wt);
    chk("no_wait_inside_beat", wt, 0);
    push_exp(c, 0, 1, 8'd40, put(put('0, 0, w[5]), 1, w[6]));
    bus.cfg_gap = 4'd0;
    drain();

    // val without sop while idle
    send(0, 0, 8'd32, rnd_word(), c, wt);
    exp_err++;
    drain();

    // vbc=0 word in mid-packet is dropped
    w[0] = rnd_word(); w[1] = rnd_word();
    send(1, 0, 8'd32, w[0], c, wt);
    send(0, 0, 8'd0, rnd_word(), c, wt);
    exp_err++;
    send(0, 1, 8'd32, w[1], c, wt);
    push_exp(c, 1, 1, 8'd64, put(put('0, 0, w[0]), 1, w[1]));
    drain();

    // sop at the 4th word restarts the packet
    for (int k = 0; k < 5; k++) w[k] = rnd_word();
    for (int k = 0; k < 3; k++) send(k == 0, 0, 8'd32, w[k], c, wt);
    send(1, 0, 8'd32, w[3], c, wt);
    exp_err++;
    send(0, 1, 8'd16, w[4], c, wt);
    push_exp(c, 1, 1, 8'd48, put(put('0, 0, w[3]), 1, w[4]));
    drain();

    // single-word packet
    w[0] = rnd_word();
    send(1, 1, 8'd20, w[0], c, wt);
    push_exp(c, 1, 1, 8'd20, put('0, 0, w[0]));
    drain();
    chk("idle_after_single", bus.idle, 1);

    // short word without eop closes the packet as if eop
    w[0] = rnd_word(); w[1] = rnd_word();
    send(1, 0, 8'd32, w[0], c, wt);
    send(0, 0, 8'd10, w[1], c, wt);
    exp_err++;
    push_exp(c, 1, 1, 8'd42, put(put('0, 0, w[0]), 1, w[1]));
    drain();
    chk("idle_after_short", bus.idle, 1);

    // asynchronous reset mid-packet discards the partial beat
    for (int k = 0; k < 3; k++) send(k == 0, 0, 8'd32, rnd_word(), c, wt);
    chk("idle_mid_pkt", bus.idle, 0);
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_rst_ready", bus.ready, 1);
    chk("async_rst_idle", bus.idle, 1);
    repeat (3) @(negedge clk);
    reset_L = 1'b1;
    drain();
    w[0] = rnd_word(); w[1] = rnd_word();
    send(1, 0, 8'd32, w[0], c, wt);
    send(0, 1, 8'd32, w[1], c, wt);
    push_exp(c, 1, 1, 8'd64, put(put('0, 0, w[0]), 1, w[1]));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
